rename_rf_ckpt: RTL and testbench

- Next-generation renaming register file for PDL out-of-order pipelines: architectural-to-physical name map, physical data file, busy bits and free list.
- Adds parametrised read-port count and a FIFO of map/free-list checkpoints, so a mispredicted branch recovers in one cycle.
- Sits between the decode/rename stage and the writeback/commit stages of a generated pipeline.

---
 rtl/rename_rf_ckpt.sv | 187 ++++++++++++++++++
 tb/tb_rename_rf_ckpt.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_rf_ckpt.sv
// Renaming register file: arch->phys name map, physical data, busy bits, free list,
// plus a FIFO of map/free-list checkpoints for one-cycle recovery. Same-cycle write bypass under RENAME_RF_BYPASS_EN.
module rename_rf_ckpt #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int NAME_W   = 6,
    parameter int NUM_ARCH = 32,
    parameter int NUM_PHYS = 64,
    parameter int NUM_RD   = 2,
    parameter int NUM_CKPT = 4,
    parameter int CKPT_W   = 2
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       ALLOC_E,
    input  logic [ADDR_W-1:0]          ALLOC_ADDR,
    output logic                       ALLOC_READY,
    output logic [NAME_W-1:0]          ALLOC_NAME,
    input  logic [NUM_RD*ADDR_W-1:0]   RD_ADDR,
    output logic [NUM_RD*NAME_W-1:0]   RD_NAME,
    input  logic [NUM_RD*NAME_W-1:0]   DRD_NAME,
    output logic [NUM_RD*DATA_W-1:0]   DRD_DATA,
    output logic [NUM_RD-1:0]          DRD_VALID,
    input  logic                       WE,
    input  logic [NAME_W-1:0]          WR_NAME,
    input  logic [DATA_W-1:0]          WR_DATA,
    input  logic                       FE,
    input  logic [NAME_W-1:0]          FREE_NAME,
    input  logic                       CKPT_E,
    output logic                       CKPT_READY,
    output logic [CKPT_W-1:0]          CKPT_ID,
    input  logic                       ROLLBACK_E,
    input  logic [CKPT_W-1:0]          ROLLBACK_ID,
    input  logic                       RELEASE_E
);
    localparam int CNT_W = CKPT_W + 1;

    logic [NAME_W-1:0]   names_q [NUM_ARCH];
    logic [NAME_W-1:0]   names_d [NUM_ARCH];
    logic [NAME_W-1:0]   old_q   [NUM_PHYS];
    logic [NAME_W-1:0]   old_d   [NUM_PHYS];
    logic [DATA_W-1:0]   phys_q  [NUM_PHYS];
    logic [DATA_W-1:0]   phys_d  [NUM_PHYS];
    logic [NUM_PHYS-1:0] free_q, free_d, busy_q, busy_d;
    logic [NAME_W-1:0]   ck_names_q [NUM_CKPT][NUM_ARCH];
    logic [NAME_W-1:0]   ck_names_d [NUM_CKPT][NUM_ARCH];
    logic [NUM_PHYS-1:0] ck_free_q [NUM_CKPT];
    logic [NUM_PHYS-1:0] ck_free_d [NUM_CKPT];
    logic [CKPT_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic                alloc_ready, alloc_fire, ckpt_fire, rel_fire, rb_ok;
    logic [NAME_W-1:0]   alloc_name, drd_nm;
    logic [NUM_PHYS-1:0] fe_vec;

    // Distance of a slot from the oldest entry, modulo the FIFO depth.
    function automatic logic [CNT_W-1:0] ckpt_off(input logic [CKPT_W-1:0] id,
                                                  input logic [CKPT_W-1:0] head);
        logic [CNT_W-1:0] off;
        if (id >= head) off = CNT_W'(id) - CNT_W'(head);
        else            off = CNT_W'(id) + CNT_W'(NUM_CKPT) - CNT_W'(head);
        return off;
    endfunction

    function automatic logic [CKPT_W-1:0] ckpt_inc(input logic [CKPT_W-1:0] p);
        return (int'(p) == NUM_CKPT - 1) ? '0 : p + 1'b1;
    endfunction

    function automatic logic slot_valid(input logic [CKPT_W-1:0] id, input logic [CKPT_W-1:0] head,
                                        input logic [CNT_W-1:0] cnt);
        return (int'(id) < NUM_CKPT) && (ckpt_off(id, head) < cnt);
    endfunction

    always_comb begin
        alloc_ready = |free_q;
        alloc_name  = '0;
        for (int i = NUM_PHYS - 1; i >= 0; i--) begin
            if (free_q[i]) alloc_name = NAME_W'(i);
        end
    end

    always_comb begin
        RD_NAME   = '0;
        DRD_DATA  = '0;
        DRD_VALID = '0;
        drd_nm    = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            RD_NAME[k*NAME_W +: NAME_W] = names_q[RD_ADDR[k*ADDR_W +: ADDR_W]];
            drd_nm = DRD_NAME[k*NAME_W +: NAME_W];
            DRD_DATA[k*DATA_W +: DATA_W] = phys_q[drd_nm];
            DRD_VALID[k] = !busy_q[drd_nm];
`ifdef RENAME_RF_BYPASS_EN
            if (WE && (WR_NAME == drd_nm)) begin
                DRD_DATA[k*DATA_W +: DATA_W] = WR_DATA;
                DRD_VALID[k] = 1'b1;
            end
`endif
        end
    end

    assign ALLOC_READY = alloc_ready;
    assign ALLOC_NAME  = alloc_name;
    assign CKPT_READY  = (int'(count_q) != NUM_CKPT);
    assign CKPT_ID     = tail_q;

    // Rollback suppresses alloc/checkpoint/release even when its id turns out invalid.
    assign rb_ok      = ROLLBACK_E && slot_valid(ROLLBACK_ID, head_q, count_q);
    assign alloc_fire = ALLOC_E && alloc_ready && !ROLLBACK_E;
    assign ckpt_fire  = CKPT_E && CKPT_READY && !ROLLBACK_E;
    assign rel_fire   = RELEASE_E && (count_q != '0) && !ROLLBACK_E;

    always_comb begin
        names_d    = names_q;
        old_d      = old_q;
        phys_d     = phys_q;
        free_d     = free_q;
        busy_d     = busy_q;
        ck_names_d = ck_names_q;
        ck_free_d  = ck_free_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q + CNT_W'(ckpt_fire) - CNT_W'(rel_fire);
        fe_vec     = '0;
        if (FE) fe_vec[old_q[FREE_NAME]] = 1'b1;

        if (alloc_fire) begin
            busy_d[alloc_name]  = 1'b1;
            free_d[alloc_name]  = 1'b0;
            old_d[alloc_name]   = names_q[ALLOC_ADDR];
            names_d[ALLOC_ADDR] = alloc_name;
        end
        free_d = free_d | fe_vec;

        if (rb_ok) begin
            names_d = ck_names_q[ROLLBACK_ID];
            free_d  = ck_free_q[ROLLBACK_ID] | fe_vec;
            busy_d  = busy_q & ~(free_d & ~free_q);
            tail_d  = ROLLBACK_ID;
            count_d = ckpt_off(ROLLBACK_ID, head_q);
        end

        if (WE) begin
            phys_d[WR_NAME] = WR_DATA;
            busy_d[WR_NAME] = 1'b0;
        end

        for (int s = 0; s < NUM_CKPT; s++) begin
            if (slot_valid(CKPT_W'(s), head_q, count_q)) ck_free_d[s] = ck_free_q[s] | fe_vec;
        end
        if (ckpt_fire) begin
            ck_names_d[tail_q] = names_d;
            ck_free_d[tail_q]  = free_d;
            tail_d             = ckpt_inc(tail_q);
        end
        if (rel_fire) head_d = ckpt_inc(head_q);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < NUM_ARCH; i++) names_q[i] <= NAME_W'(i);
            for (int i = 0; i < NUM_PHYS; i++) begin
                old_q[i]  <= '0;
                phys_q[i] <= '0;
                free_q[i] <= (i >= NUM_ARCH);
            end
            busy_q <= '0;
            for (int s = 0; s < NUM_CKPT; s++) begin
                for (int i = 0; i < NUM_ARCH; i++) ck_names_q[s][i] <= '0;
                ck_free_q[s] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            names_q    <= names_d;
            old_q      <= old_d;
            phys_q     <= phys_d;
            free_q     <= free_d;
            busy_q     <= busy_d;
            ck_names_q <= ck_names_d;
            ck_free_q  <= ck_free_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end
endmodule

// File: tb/tb_rename_rf_ckpt.sv
// Self-checking bench for rename_rf_ckpt; also checks same-cycle bypass when RENAME_RF_BYPASS_EN is defined.
module tb_rename_rf_ckpt;
    logic        CLK, RST;
    logic        ALLOC_E, ALLOC_READY;
    logic [4:0]  ALLOC_ADDR;
    logic [5:0]  ALLOC_NAME;
    logic [9:0]  RD_ADDR;
    logic [11:0] RD_NAME;
    logic [11:0] DRD_NAME;
    logic [63:0] DRD_DATA;
    logic [1:0]  DRD_VALID;
    logic        WE, FE, CKPT_E, CKPT_READY, ROLLBACK_E, RELEASE_E;
    logic [5:0]  WR_NAME, FREE_NAME;
    logic [31:0] WR_DATA;
    logic [1:0]  CKPT_ID, ROLLBACK_ID;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];
    logic [5:0]  model_map [32];
    logic [4:0]  ra0, ra1;

    rename_rf_ckpt dut (
        .CLK(CLK), .RST(RST),
        .ALLOC_E(ALLOC_E), .ALLOC_ADDR(ALLOC_ADDR), .ALLOC_READY(ALLOC_READY), .ALLOC_NAME(ALLOC_NAME),
        .RD_ADDR(RD_ADDR), .RD_NAME(RD_NAME),
        .DRD_NAME(DRD_NAME), .DRD_DATA(DRD_DATA), .DRD_VALID(DRD_VALID),
        .WE(WE), .WR_NAME(WR_NAME), .WR_DATA(WR_DATA),
        .FE(FE), .FREE_NAME(FREE_NAME),
        .CKPT_E(CKPT_E), .CKPT_READY(CKPT_READY), .CKPT_ID(CKPT_ID),
        .ROLLBACK_E(ROLLBACK_E), .ROLLBACK_ID(ROLLBACK_ID), .RELEASE_E(RELEASE_E)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // checking and scoreboard
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_val(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic compare(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        if (exp_q.size() == 0) e = 'x;
        else e = exp_q.pop_front();
        check(tag, obs, e);
    endtask

    // drivers
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        ALLOC_E = 0; ALLOC_ADDR = 0; RD_ADDR = 0; DRD_NAME = 0;
        WE = 0; WR_NAME = 0; WR_DATA = 0; FE = 0; FREE_NAME = 0;
        CKPT_E = 0; ROLLBACK_E = 0; ROLLBACK_ID = 0; RELEASE_E = 0;
    endtask

    task automatic do_reset();
        idle();
        @(negedge CLK);
        RST = 0;
        #2;
        RST = 1;
        tick();
    endtask

    task automatic alloc(input logic [4:0] a);
        ALLOC_E = 1; ALLOC_ADDR = a;
        tick();
        ALLOC_E = 0;
    endtask

    task automatic ckpt();
        CKPT_E = 1;
        tick();
        CKPT_E = 0;
    endtask

    task automatic rollback(input logic [1:0] id);
        ROLLBACK_E = 1; ROLLBACK_ID = id;
        tick();
        ROLLBACK_E = 0;
    endtask

    task automatic release_ck();
        RELEASE_E = 1;
        tick();
        RELEASE_E = 0;
    endtask

    task automatic free_name(input logic [5:0] n);
        FE = 1; FREE_NAME = n;
        tick();
        FE = 0;
    endtask

    initial begin
        RST = 1;
        idle();

        // reset state
        do_reset();
        RD_ADDR = {5'd9, 5'd3};
        DRD_NAME = {6'd40, 6'd1};
        #1;
        expect_val(1); expect_val(32); expect_val(1); expect_val(0);
        expect_val({6'd9, 6'd3}); expect_val(2'b11); expect_val(0);
        compare("rst_alloc_ready", 32'(ALLOC_READY));
        compare("rst_alloc_name", 32'(ALLOC_NAME));
        compare("rst_ckpt_ready", 32'(CKPT_READY));
        compare("rst_ckpt_id", 32'(CKPT_ID));
        compare("rst_rd_name", 32'(RD_NAME));
        compare("rst_drd_valid", 32'(DRD_VALID));
        compare("rst_drd_data0", DRD_DATA[31:0]);

        // allocate r3, then write its new name
        ALLOC_ADDR = 3;
        #1;
        expect_val(32);
        compare("alloc_r3_name", 32'(ALLOC_NAME));
        alloc(3);
        RD_ADDR = {5'd4, 5'd3};
        DRD_NAME = {6'd3, 6'd32};
        #1;
        expect_val({6'd4, 6'd32}); expect_val(2'b10); expect_val(33);
        compare("r3_mapped", 32'(RD_NAME));
        compare("n32_busy", 32'(DRD_VALID));
        compare("alloc_next_name", 32'(ALLOC_NAME));
        WE = 1; WR_NAME = 32; WR_DATA = 32'hDEAD;
        tick();
        WE = 0;
        #1;
        expect_val(32'hDEAD); expect_val(2'b11);
        compare("wr32_data", DRD_DATA[31:0]);
        compare("wr32_valid", 32'(DRD_VALID));

        // exhaust the free list, then free the name displaced from r5
        do_reset();
        for (int i = 0; i < 32; i++) alloc(5'(i));
        RD_ADDR = {5'd31, 5'd0};
        #1;
        expect_val(0); expect_val({6'd63, 6'd32});
        compare("full_alloc_ready", 32'(ALLOC_READY));
        compare("full_rd_name", 32'(RD_NAME));
        alloc(0);
        #1;
        expect_val({6'd63, 6'd32});
        compare("full_alloc_ignored", 32'(RD_NAME));
        free_name(37);
        #1;
        expect_val(1); expect_val(5);
        compare("free_alloc_ready", 32'(ALLOC_READY));
        compare("free_alloc_name", 32'(ALLOC_NAME));

        // checkpoint then rollback restores map and free list
        do_reset();
        alloc(1);
        ckpt();
        #1;
        expect_val(1);
        compare("ckpt_id_after_take", 32'(CKPT_ID));
        alloc(1);
        alloc(2);
        RD_ADDR = {5'd2, 5'd1};
        #1;
        expect_val({6'd34, 6'd33});
        compare("pre_rb_rd_name", 32'(RD_NAME));
        rollback(0);
        DRD_NAME = {6'd33, 6'd32};
        #1;
        expect_val({6'd2, 6'd32}); expect_val(33); expect_val(0); expect_val(1); expect_val(2'b10);
        compare("rb_rd_name", 32'(RD_NAME));
        compare("rb_alloc_name", 32'(ALLOC_NAME));
        compare("rb_ckpt_id", 32'(CKPT_ID));
        compare("rb_ckpt_ready", 32'(CKPT_READY));
        compare("rb_busy_cleared", 32'(DRD_VALID));
        alloc(5);
        #1;
        expect_val(34);
        compare("rb_34_free", 32'(ALLOC_NAME));

        // FIFO full / wrap / release / rollback bookkeeping
        do_reset();
        release_ck();
        for (int i = 0; i < 4; i++) begin
            #1;
            expect_val(i);
            compare("ckpt_id_seq", 32'(CKPT_ID));
            ckpt();
        end
        #1;
        expect_val(0);
        compare("ckpt_full_ready", 32'(CKPT_READY));
        ckpt();
        #1;
        expect_val(0); expect_val(0);
        compare("ckpt_5th_ready", 32'(CKPT_READY));
        compare("ckpt_5th_id", 32'(CKPT_ID));
        release_ck();
        #1;
        expect_val(1); expect_val(0);
        compare("release_ready", 32'(CKPT_READY));
        compare("release_wrap_id", 32'(CKPT_ID));
        ckpt();
        #1;
        expect_val(0); expect_val(1);
        compare("refill_ready", 32'(CKPT_READY));
        compare("refill_id", 32'(CKPT_ID));
        rollback(2);
        #1;
        expect_val(1); expect_val(2);
        compare("rb2_ready", 32'(CKPT_READY));
        compare("rb2_id", 32'(CKPT_ID));
        rollback(3);
        #1;
        expect_val(2);
        compare("rb_invalid_noop", 32'(CKPT_ID));

        // a free after the checkpoint survives rollback
        do_reset();
        alloc(7);
        ckpt();
        alloc(8);
        free_name(32);
        #1;
        expect_val(7);
        compare("fe7_alloc_name", 32'(ALLOC_NAME));
        rollback(0);
        RD_ADDR = {5'd8, 5'd7};
        #1;
        expect_val(7); expect_val({6'd8, 6'd32});
        compare("rb_keeps_free7", 32'(ALLOC_NAME));
        compare("rb_keeps_map", 32'(RD_NAME));

        // same-cycle write vs read of name 40
        do_reset();
        for (int i = 0; i < 9; i++) alloc(5'(i));
        WE = 1; WR_NAME = 40; WR_DATA = 32'h55;
        DRD_NAME = {6'd3, 6'd40};
        #1;
`ifdef RENAME_RF_BYPASS_EN
        expect_val(32'h55); expect_val(2'b11);
`else
        expect_val(0); expect_val(2'b10);
`endif
        compare("same_cycle_data", DRD_DATA[31:0]);
        compare("same_cycle_valid", 32'(DRD_VALID));
        tick();
        WE = 0;
        #1;
        expect_val(32'h55); expect_val(2'b11);
        compare("next_cycle_data", DRD_DATA[31:0]);
        compare("next_cycle_valid", 32'(DRD_VALID));

        // reset mid-operation
        RST = 0;
        RD_ADDR = {5'd8, 5'd0};
        #1;
        expect_val(32); expect_val({6'd8, 6'd0});
        compare("midrst_alloc_name", 32'(ALLOC_NAME));
        compare("midrst_rd_name", 32'(RD_NAME));
        RST = 1;
        tick();

        // random allocations against a map model
        do_reset();
        for (int i = 0; i < 32; i++) model_map[i] = 6'(i);
        for (int i = 0; i < 20; i++) begin
            ra0 = 5'($urandom_range(0, 31));
            model_map[ra0] = 6'(32 + i);
            alloc(ra0);
        end
        for (int j = 0; j < 8; j++) begin
            ra0 = 5'($urandom_range(0, 31));
            ra1 = 5'($urandom_range(0, 31));
            RD_ADDR = {ra1, ra0};
            expect_val({model_map[ra1], model_map[ra0]});
            #1;
            compare("rand_rd_name", 32'(RD_NAME));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
